// File: rtl/gpu_cmd_pkg.sv
// Shared types and default widths for the frame-synchronised GPU command buffer.
package gpu_cmd_pkg;

  localparam int CMD_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_W_DEF-1:0]  opcode;
    logic [DATA_W_DEF-1:0] data;
  } gpu_cmd_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Circular command storage with wrap-around pointers and an occupancy counter.
module gpu_cmd_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == CNT_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // An empty buffer presents zeros rather than stale storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_frame_buffer.sv
// Frame-batched GPU command buffer: drains exactly the commands queued at each frame boundary.
// Optional statistics outputs (last_batch_out, high_water_out) are enabled by GPU_CMD_STATS_EN.
module gpu_cmd_frame_buffer
  import gpu_cmd_pkg::*;
#(
  parameter int CMD_W  = CMD_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [CMD_W-1:0]  cmd_in,
  input  logic [DATA_W-1:0] cmd_data_in,
  input  logic              frame_end_in,
  output logic              exec_valid_out,
  input  logic              exec_ready_in,
  output logic [CMD_W-1:0]  exec_cmd_out,
  output logic [DATA_W-1:0] exec_data_out,
  output logic              draining_out,
  output logic              drain_done_out,
  output logic [CNT_W-1:0]  level_out,
  input  logic              clear_errors_in,
  output logic              overflow_out,
`ifdef GPU_CMD_STATS_EN
  output logic [CNT_W-1:0]  last_batch_out,
  output logic [CNT_W-1:0]  high_water_out,
`endif
  output logic              frame_overrun_out
);

  localparam int W = CMD_W + DATA_W;

  state_t           state;
  logic [CNT_W-1:0] snapshot;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] snap_level;
  logic [W-1:0]     head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign cmd_ready_out = !fifo_full;
  assign push          = cmd_valid_in && cmd_ready_out;
  assign pop           = exec_valid_out && exec_ready_in && !fifo_empty;
  assign exec_cmd_out  = head[DATA_W +: CMD_W];
  assign exec_data_out = head[DATA_W-1:0];

  // A push in the frame_end cycle belongs to the batch being snapshotted.
  assign snap_level = level_out + CNT_W'(push);

  gpu_cmd_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_in, cmd_data_in}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_out)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      snapshot       <= '0;
      remaining      <= '0;
      exec_valid_out <= 1'b0;
      draining_out   <= 1'b0;
      drain_done_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          drain_done_out <= 1'b0;
          if (frame_end_in) begin
            snapshot       <= snap_level;
            remaining      <= snap_level;
            draining_out   <= 1'b1;
            exec_valid_out <= (snap_level != '0);
            state          <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the last counted command is accepted.
          if (remaining == '0 || (pop && remaining == CNT_W'(1))) begin
            remaining      <= '0;
            exec_valid_out <= 1'b0;
            draining_out   <= 1'b0;
            drain_done_out <= 1'b1;
            state          <= DONE;
          end else if (pop) begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        DONE: begin
          drain_done_out <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          exec_valid_out <= 1'b0;
          draining_out   <= 1'b0;
          drain_done_out <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a same-cycle set takes priority over clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_out      <= 1'b0;
      frame_overrun_out <= 1'b0;
    end else begin
      if (cmd_valid_in && fifo_full)  overflow_out <= 1'b1;
      else if (clear_errors_in)       overflow_out <= 1'b0;
      if (frame_end_in && state != IDLE) frame_overrun_out <= 1'b1;
      else if (clear_errors_in)          frame_overrun_out <= 1'b0;
    end
  end

`ifdef GPU_CMD_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_batch_out <= '0;
      high_water_out <= '0;
    end else begin
      if (state == DONE) last_batch_out <= snapshot;
      if (clear_errors_in)                high_water_out <= level_out;
      else if (level_out > high_water_out) high_water_out <= level_out;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_cmd_frame_buffer.sv
// Bench for gpu_cmd_frame_buffer: per-cycle vector table plus scoreboard of executed commands.
module tb_gpu_cmd_frame_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_in = 1'b1;
  logic             cmd_valid_in = 1'b0;
  logic             cmd_ready_out;
  logic [7:0]       cmd_in = '0;
  logic [15:0]      cmd_data_in = '0;
  logic             frame_end_in = 1'b0;
  logic             exec_valid_out;
  logic             exec_ready_in = 1'b0;
  logic [7:0]       exec_cmd_out;
  logic [15:0]      exec_data_out;
  logic             draining_out;
  logic             drain_done_out;
  logic [CNT_W-1:0] level_out;
  logic             clear_errors_in = 1'b0;
  logic             overflow_out;
  logic             frame_overrun_out;
`ifdef GPU_CMD_STATS_EN
  logic [CNT_W-1:0] last_batch_out;
  logic [CNT_W-1:0] high_water_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt = 0;
  logic [23:0] sb_q[$];

  always #5 clk = ~clk;

  gpu_cmd_frame_buffer #(.CMD_W(8), .DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .cmd_valid_in      (cmd_valid_in),
    .cmd_ready_out     (cmd_ready_out),
    .cmd_in            (cmd_in),
    .cmd_data_in       (cmd_data_in),
    .frame_end_in      (frame_end_in),
    .exec_valid_out    (exec_valid_out),
    .exec_ready_in     (exec_ready_in),
    .exec_cmd_out      (exec_cmd_out),
    .exec_data_out     (exec_data_out),
    .draining_out      (draining_out),
    .drain_done_out    (drain_done_out),
    .level_out         (level_out),
    .clear_errors_in   (clear_errors_in),
    .overflow_out      (overflow_out),
`ifdef GPU_CMD_STATS_EN
    .last_batch_out    (last_batch_out),
    .high_water_out    (high_water_out),
`endif
    .frame_overrun_out (frame_overrun_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: model occupancy from the queue, check every accepted command in order.
  always @(negedge clk) begin
    if (rst_in) begin
      sb_q.delete();
    end else begin
      logic was_full;
      was_full = (sb_q.size() == DEPTH);
      chk("level", 32'(level_out), 32'(sb_q.size()));
      chk("cmd_ready", 32'(cmd_ready_out), 32'(!was_full));
      if (exec_valid_out && exec_ready_in) begin
        if (sb_q.size() == 0) begin
          chk("pop_from_empty", 32'(1), 32'(0));
        end else begin
          chk("exec_head", 32'({exec_cmd_out, exec_data_out}), 32'(sb_q[0]));
          void'(sb_q.pop_front());
        end
        pop_cnt++;
      end
      if (cmd_valid_in && !was_full) sb_q.push_back({cmd_in, cmd_data_in});
    end
  end

  task automatic set_in(input logic v, input logic [7:0] c, input logic [15:0] d,
                        input logic fe, input logic rdy);
    cmd_valid_in  = v;
    cmd_in        = c;
    cmd_data_in   = d;
    frame_end_in  = fe;
    exec_ready_in = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic wait_done(input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (drain_done_out === 1'b1) seen = 1'b1;
      next_cycle();
    end
    chk("drain_done_seen", 32'(seen), 32'(1));
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        fe;
    logic        rdy;
    logic        ev;
    logic        dr;
    logic        dd;
    int          lvl;
  } row_t;

  row_t tbl[13];

  initial begin : main
    int p0;
    // Three commands, frame boundary, then a zero-length frame.
    tbl[0]  = '{1'b1, 8'h10, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 8'h10, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{1'b1, 8'h10, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[3]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    tbl[4]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3};
    tbl[5]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[12] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

    repeat (3) next_cycle();
    rst_in = 1'b0;

    @(negedge clk);
    chk("rst_exec_valid", 32'(exec_valid_out), 32'(0));
    chk("rst_draining", 32'(draining_out), 32'(0));
    chk("rst_drain_done", 32'(drain_done_out), 32'(0));
    chk("rst_exec_word", 32'({exec_cmd_out, exec_data_out}), 32'(0));
    chk("rst_flags", 32'({overflow_out, frame_overrun_out}), 32'(0));
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].v, tbl[i].cmd, tbl[i].data, tbl[i].fe, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("row%0d_exec_valid", i), 32'(exec_valid_out), 32'(tbl[i].ev));
      chk($sformatf("row%0d_draining", i), 32'(draining_out), 32'(tbl[i].dr));
      chk($sformatf("row%0d_drain_done", i), 32'(drain_done_out), 32'(tbl[i].dd));
      chk($sformatf("row%0d_level", i), 32'(level_out), 32'(tbl[i].lvl));
`ifdef GPU_CMD_STATS_EN
      if (i == 8) begin
        chk("last_batch", 32'(last_batch_out), 32'(3));
        chk("high_water", 32'(high_water_out), 32'(3));
      end
`endif
      next_cycle();
    end

    // Two queued, four more arrive mid-drain while the executor stalls.
    set_in(1'b1, 8'h20, 16'h00A1, 1'b0, 1'b0); step();
    set_in(1'b1, 8'h20, 16'h00A2, 1'b0, 1'b0); step();
    set_in(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0); step();
    for (int k = 0; k < 5; k++) begin
      set_in(k < 4, 8'h21, 16'h00B1 + 16'(k), 1'b0, 1'b0);
      @(negedge clk);
      chk("stall_exec_valid", 32'(exec_valid_out), 32'(1));
      chk("stall_head", 32'({exec_cmd_out, exec_data_out}), 32'h2000A1);
      next_cycle();
    end
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    @(negedge clk); chk("s2_pop1_valid", 32'(exec_valid_out), 32'(1)); next_cycle();
    @(negedge clk); chk("s2_pop2_valid", 32'(exec_valid_out), 32'(1)); next_cycle();
    @(negedge clk);
    chk("s2_drain_done", 32'(drain_done_out), 32'(1));
    chk("s2_exec_valid_off", 32'(exec_valid_out), 32'(0));
    chk("s2_level_after", 32'(level_out), 32'(4));
    next_cycle();
    set_in(1'b0, 8'h00, 16'h0000, 1'b1, 1'b1); step();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    wait_done(20);

    // Fill to DEPTH, overflow, then push+pop at level 15 and an overrun frame_end.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 8'h30, 16'h3000 + 16'(i), 1'b0, 1'b0); step();
    end
    set_in(1'b1, 8'h3F, 16'hDEAD, 1'b0, 1'b0);
    @(negedge clk); chk("full_ready_low", 32'(cmd_ready_out), 32'(0)); next_cycle();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("overflow_set", 32'(overflow_out), 32'(1));
    chk("full_level", 32'(level_out), 32'(DEPTH));
    next_cycle();
    p0 = pop_cnt;
    set_in(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0); step();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    @(negedge clk); chk("s3_exec_valid", 32'(exec_valid_out), 32'(1)); next_cycle();
    set_in(1'b1, 8'h31, 16'hBEEF, 1'b1, 1'b1);
    @(negedge clk); chk("s3_level15", 32'(level_out), 32'(15)); next_cycle();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("pushpop_level15", 32'(level_out), 32'(15));
    chk("frame_overrun_set", 32'(frame_overrun_out), 32'(1));
    next_cycle();
    wait_done(40);
    chk("batch_count", 32'(pop_cnt - p0), 32'(DEPTH));
    @(negedge clk);
    chk("s3_left_over", 32'(level_out), 32'(1));
    chk("s3_idle_after", 32'(draining_out), 32'(0));
    chk("overflow_sticky", 32'(overflow_out), 32'(1));
    next_cycle();
    clear_errors_in = 1'b1; step();
    clear_errors_in = 1'b0;
    @(negedge clk);
    chk("clear_overflow", 32'(overflow_out), 32'(0));
    chk("clear_overrun", 32'(frame_overrun_out), 32'(0));
    next_cycle();
    set_in(1'b0, 8'h00, 16'h0000, 1'b1, 1'b1); step();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    wait_done(10);

    // Reset mid-drain with five commands still owed.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 8'h40, 16'h4000 + 16'(i), 1'b0, 1'b0); step();
    end
    set_in(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0); step();
    set_in(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
    repeat (3) step();
    @(negedge clk); chk("pre_rst_level", 32'(level_out), 32'(5)); next_cycle();
    rst_in = 1'b1; step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_exec_valid", 32'(exec_valid_out), 32'(0));
    chk("mid_rst_draining", 32'(draining_out), 32'(0));
    chk("mid_rst_level", 32'(level_out), 32'(0));
    chk("mid_rst_exec_word", 32'({exec_cmd_out, exec_data_out}), 32'(0));
    next_cycle();
    @(negedge clk);
    chk("mid_rst_still_idle", 32'({exec_valid_out, draining_out, drain_done_out}), 32'(0));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
